// File: rtl/sram_access_seq.sv
// Request/handshake sequencer driving the 1Mx16 SRAM strobes with programmable wait states.
// Define MMIO_EN to map word address 0xFFFF onto Switches (read) and Hex_Out (write).
module sram_access_seq #(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] Wdata,
  output logic [15:0] Rdata,
  output logic        Done,
  output logic        Busy,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] Data_to_SRAM,
  output logic        Data_OE,
  output logic [19:0] ADDR,
  output logic        CE,
  output logic        OE,
  output logic        WE,
  output logic        UB,
  output logic        LB,
  input  logic [15:0] Switches,
  output logic [15:0] Hex_Out
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StRdStb,
    StWrStb,
    StWrHold,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        access;
  logic        oe_n;
  logic        we_n;
  logic        capture;
  logic        mmio_hit;
  logic [15:0] rd_src;

`ifdef MMIO_EN
  logic [15:0] hex_q;

  assign mmio_hit = (addr_q == 16'hFFFF);
  assign rd_src   = mmio_hit ? Switches : Data_from_SRAM;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hex_q <= 16'h0000;
    end else if (state_q == StWrHold && mmio_hit) begin
      hex_q <= wdata_q;
    end
  end

  assign Hex_Out = hex_q;
`else
  logic unused_switches;

  assign mmio_hit        = 1'b0;
  assign rd_src          = Data_from_SRAM;
  assign Hex_Out         = 16'h0000;
  assign unused_switches = ^Switches;
`endif

  assign capture = (state_q == StRdStb) && (cnt_q == 4'd0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Request fields are frozen at acceptance; later input changes are ignored.
      if (state_q == StIdle && Req) begin
        wr_q    <= Wr;
        addr_q  <= Addr;
        wdata_q <= Wdata;
      end
      if (capture) begin
        rdata_q <= rd_src;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    oe_n    = 1'b1;
    we_n    = 1'b1;
    Data_OE = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Req) begin
          state_d = StSetup;
        end
      end
      StSetup: begin
        access = 1'b1;
        if (wr_q) begin
          Data_OE = 1'b1;
          state_d = StWrStb;
          cnt_d   = 4'(WR_WAIT - 1);
        end else begin
          oe_n    = 1'b0;
          state_d = StRdStb;
          cnt_d   = 4'(RD_WAIT - 1);
        end
      end
      StRdStb: begin
        access = 1'b1;
        oe_n   = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrStb: begin
        access  = 1'b1;
        we_n    = 1'b0;
        Data_OE = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrHold: begin
        // WE already high, bus still driven to give the SRAM data hold time.
        access  = 1'b1;
        Data_OE = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        Done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign CE           = ~(access & ~mmio_hit);
  assign UB           = CE;
  assign LB           = CE;
  assign OE           = oe_n;
  assign WE           = we_n;
  assign Busy         = (state_q != StIdle);
  assign Rdata        = rdata_q;
  assign ADDR         = {4'b0000, addr_q};
  assign Data_to_SRAM = wdata_q;

endmodule

// File: tb/tb_sram_access_seq.sv
// Directed bench for sram_access_seq with a small SRAM model on the low address byte.
module tb_sram_access_seq;

  logic        Clk;
  logic        Reset;
  logic        Req;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] Wdata;
  logic [15:0] Rdata;
  logic        Done;
  logic        Busy;
  logic [15:0] Data_from_SRAM;
  logic [15:0] Data_to_SRAM;
  logic        Data_OE;
  logic [19:0] ADDR;
  logic        CE, OE, WE, UB, LB;
  logic [15:0] Switches;
  logic [15:0] Hex_Out;

  logic [15:0] mem [0:255];
  int          n_checks;
  int          n_pass;

  sram_access_seq #(
    .RD_WAIT(2),
    .WR_WAIT(2)
  ) u_dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Req           (Req),
    .Wr            (Wr),
    .Addr          (Addr),
    .Wdata         (Wdata),
    .Rdata         (Rdata),
    .Done          (Done),
    .Busy          (Busy),
    .Data_from_SRAM(Data_from_SRAM),
    .Data_to_SRAM  (Data_to_SRAM),
    .Data_OE       (Data_OE),
    .ADDR          (ADDR),
    .CE            (CE),
    .OE            (OE),
    .WE            (WE),
    .UB            (UB),
    .LB            (LB),
    .Switches      (Switches),
    .Hex_Out       (Hex_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign Data_from_SRAM = (!CE && !OE) ? mem[ADDR[7:0]] : 16'h0000;

  always @(posedge Clk) begin
    if (!CE && !WE && Data_OE) begin
      mem[ADDR[7:0]] <= Data_to_SRAM;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h34] = 16'hBEEF;
    mem[8'hFF] = 16'h7777;
    Reset    = 1'b1;
    Req      = 1'b0;
    Wr       = 1'b0;
    Addr     = 16'h0000;
    Wdata    = 16'h0000;
    Switches = 16'h00F0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);

    check("rst_ce", CE, 1);
    check("rst_oe", OE, 1);
    check("rst_we", WE, 1);
    check("rst_ublb", {UB, LB}, 2'b11);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_rdata", Rdata, 0);
    check("rst_data_oe", Data_OE, 0);
    check("rst_addr", ADDR, 0);
    check("rst_hex", Hex_Out, 0);

    // Read 0x1234: OE low cycles 1-3, Done at cycle 4.
    Req  = 1'b1;
    Wr   = 1'b0;
    Addr = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      Req  = 1'b0;
      Addr = 16'hDEAD;
      check("rd_oe", OE, (c <= 3) ? 1'b0 : 1'b1);
      check("rd_ce", CE, (c <= 3) ? 1'b0 : 1'b1);
      check("rd_we", WE, 1);
      check("rd_data_oe", Data_OE, 0);
      check("rd_done", Done, (c == 4) ? 1'b1 : 1'b0);
      check("rd_busy", Busy, (c <= 4) ? 1'b1 : 1'b0);
      if (c == 1) check("rd_addr", ADDR, 20'h01234);
    end
    check("rd_rdata", Rdata, 16'hBEEF);
    check("rd_addr_idle", ADDR, 20'h01234);

    // Write 0xA5A5 to 0x0042: WE low cycles 2-3, Data_OE cycles 1-4, Done at cycle 5.
    Req   = 1'b1;
    Wr    = 1'b1;
    Addr  = 16'h0042;
    Wdata = 16'hA5A5;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      Req   = 1'b0;
      Wr    = 1'b0;
      Wdata = 16'h0000;
      check("wr_we", WE, (c == 2 || c == 3) ? 1'b0 : 1'b1);
      check("wr_data_oe", Data_OE, (c <= 4) ? 1'b1 : 1'b0);
      check("wr_oe", OE, 1);
      check("wr_ce", CE, (c <= 4) ? 1'b0 : 1'b1);
      check("wr_done", Done, (c == 5) ? 1'b1 : 1'b0);
      if (c == 4) check("wr_hold_data", Data_to_SRAM, 16'hA5A5);
    end
    check("wr_mem", mem[8'h42], 16'hA5A5);
    check("wr_rdata_kept", Rdata, 16'hBEEF);

    // Req held high: one access per 5 cycles, nothing extra accepted in DONE.
    Req  = 1'b1;
    Wr   = 1'b0;
    Addr = 16'h1234;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      check("hold_done", Done, (c % 5 == 4) ? 1'b1 : 1'b0);
      check("hold_busy", Busy, (c % 5 == 0) ? 1'b0 : 1'b1);
    end
    Req = 1'b0;
    repeat (6) @(negedge Clk);
    check("hold_idle", Busy, 0);

    // Reset while in WR_STB.
    Req   = 1'b1;
    Wr    = 1'b1;
    Addr  = 16'h0050;
    Wdata = 16'h1111;
    @(negedge Clk);
    Req = 1'b0;
    @(negedge Clk);
    check("mid_we_low", WE, 0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("mid_ce", CE, 1);
    check("mid_strobes", {OE, WE, UB, LB}, 4'b1111);
    check("mid_data_oe", Data_OE, 0);
    check("mid_busy", Busy, 0);
    check("mid_rdata", Rdata, 0);
    for (int c = 0; c < 4; c++) begin
      check("mid_no_done", Done, 0);
      @(negedge Clk);
    end

`ifdef MMIO_EN
    Req   = 1'b1;
    Wr    = 1'b1;
    Addr  = 16'hFFFF;
    Wdata = 16'h1357;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      Req = 1'b0;
      check("mmio_wr_ce", CE, 1);
      check("mmio_wr_done", Done, (c == 5) ? 1'b1 : 1'b0);
      if (c == 4) check("mmio_hex_early", Hex_Out, 0);
      if (c == 5) check("mmio_hex", Hex_Out, 16'h1357);
    end
    Req  = 1'b1;
    Wr   = 1'b0;
    Addr = 16'hFFFF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      Req = 1'b0;
      check("mmio_rd_ce", CE, 1);
      check("mmio_rd_done", Done, (c == 4) ? 1'b1 : 1'b0);
    end
    check("mmio_rdata", Rdata, 16'h00F0);
`else
    Req  = 1'b1;
    Wr   = 1'b0;
    Addr = 16'hFFFF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      Req = 1'b0;
      if (c == 1) check("ffff_ce", CE, 0);
      if (c == 1) check("ffff_addr", ADDR, 20'h0FFFF);
      check("ffff_done", Done, (c == 4) ? 1'b1 : 1'b0);
    end
    check("ffff_rdata", Rdata, 16'h7777);
    check("ffff_hex", Hex_Out, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
